// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: optional input synchroniser, per-channel
// debounce filter, rise/fall/both mode selection and sticky pending flags.
module multi_edge_detector #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     level_in,
  input  logic [2*WIDTH-1:0]   mode_in,
  input  logic [WIDTH-1:0]     clear_in,
  output logic [WIDTH-1:0]     level_out,
  output logic [WIDTH-1:0]     rise_out,
  output logic [WIDTH-1:0]     fall_out,
  output logic [WIDTH-1:0]     edge_out,
  output logic [WIDTH-1:0]     pending_out,
  output logic                 any_pending_out
);

  localparam int CNT_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  logic [WIDTH-1:0] sync_lvl;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [WIDTH-1:0] chain_q [SYNC_STAGES];

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          for (int k = 0; k < SYNC_STAGES; k++) chain_q[k] <= '0;
        end else begin
          chain_q[0] <= level_in;
          for (int k = 1; k < SYNC_STAGES; k++) chain_q[k] <= chain_q[k-1];
        end
      end

      assign sync_lvl = chain_q[SYNC_STAGES-1];
    end else begin : g_bypass
      assign sync_lvl = level_in;
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q    [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] edge_next;
  logic [WIDTH-1:0] pending_next;

  // A mismatch must survive DEBOUNCE extra cycles; any return to the
  // accepted level restarts the count from zero.
  always_comb begin
    differ    = '0;
    accept    = '0;
    edge_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i]  = '0;
      differ[i]    = sync_lvl[i] ^ level_out[i];
      accept[i]    = differ[i] && (cnt_q[i] == CNT_MAX);
      edge_next[i] = accept[i] & ((sync_lvl[i] & mode_in[2*i]) |
                                  (~sync_lvl[i] & mode_in[2*i+1]));
      if (differ[i] && !accept[i]) cnt_next[i] = cnt_q[i] + CNT_W'(1);
    end
    // A new edge beats a simultaneous clear so no event is lost.
    pending_next = edge_next | (pending_out & ~clear_in);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      level_out       <= '0;
      rise_out        <= '0;
      fall_out        <= '0;
      edge_out        <= '0;
      pending_out     <= '0;
      any_pending_out <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_next[i];
      level_out       <= level_out ^ accept;
      rise_out        <= accept & sync_lvl;
      fall_out        <= accept & ~sync_lvl;
      edge_out        <= edge_next;
      pending_out     <= pending_next;
      any_pending_out <= |pending_next;
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: a debounced instance (2 sync stages, 3 debounce)
// and a bypass instance (0/0), each compared against a window-based reference model.
module tb_multi_edge_detector;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DB = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]   level_a = '0, clear_a = '0;
  logic [2*W-1:0] mode_a  = '0;
  logic [W-1:0]   lvl_a, rise_a, fall_a, edge_a, pend_a;
  logic           any_a;

  logic [W-1:0]   level_b = '0, clear_b = '0;
  logic [2*W-1:0] mode_b  = '1;
  logic [W-1:0]   lvl_b, rise_b, fall_b, edge_b, pend_b;
  logic           any_b;

  multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE(DB)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .level_in(level_a), .mode_in(mode_a),
    .clear_in(clear_a), .level_out(lvl_a), .rise_out(rise_a), .fall_out(fall_a),
    .edge_out(edge_a), .pending_out(pend_a), .any_pending_out(any_a));

  multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(0), .DEBOUNCE(0)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .level_in(level_b), .mode_in(mode_b),
    .clear_in(clear_b), .level_out(lvl_b), .rise_out(rise_b), .fall_out(fall_b),
    .edge_out(edge_b), .pending_out(pend_b), .any_pending_out(any_b));

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [W-1:0] rise_mask(input logic [2*W-1:0] m);
    logic [W-1:0] r;
    for (int c = 0; c < W; c++) r[c] = m[2*c];
    return r;
  endfunction

  function automatic logic [W-1:0] fall_mask(input logic [2*W-1:0] m);
    logic [W-1:0] r;
    for (int c = 0; c < W; c++) r[c] = m[2*c+1];
    return r;
  endfunction

  // Model A: s is level_in as seen SS edges ago; a channel accepts when
  // the last DB+1 values of s all disagree with the accepted level.
  logic [W-1:0] in_hist[$];
  logic [W-1:0] s_hist[$];
  logic [W-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_edge = '0, m_pend = '0;
  logic         m_any = 1'b0;
  logic [W-1:0] s_now, acc;
  bit           all_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_hist.delete();
      s_hist.delete();
      m_level = '0; m_rise = '0; m_fall = '0; m_edge = '0; m_pend = '0; m_any = 1'b0;
    end else begin
      in_hist.push_front(level_a);
      if (in_hist.size() > SS + 1) void'(in_hist.pop_back());
      s_now = (in_hist.size() > SS) ? in_hist[SS] : '0;
      s_hist.push_front(s_now);
      if (s_hist.size() > DB + 1) void'(s_hist.pop_back());
      for (int c = 0; c < W; c++) begin
        all_diff = (s_hist.size() == DB + 1);
        foreach (s_hist[j]) if (s_hist[j][c] == m_level[c]) all_diff = 1'b0;
        acc[c] = all_diff;
      end
      m_rise  = acc & s_now;
      m_fall  = acc & ~s_now;
      m_edge  = (m_rise & rise_mask(mode_a)) | (m_fall & fall_mask(mode_a));
      m_level = m_level ^ acc;
      m_pend  = m_edge | (m_pend & ~clear_a);
      m_any   = |m_pend;
    end
  end

  // Model B: no synchroniser and no debounce, so any change is an edge.
  logic [W-1:0] mb_level = '0, mb_rise = '0, mb_fall = '0, mb_edge = '0, mb_pend = '0;
  logic         mb_any = 1'b0;
  logic [W-1:0] acc_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_level = '0; mb_rise = '0; mb_fall = '0; mb_edge = '0; mb_pend = '0; mb_any = 1'b0;
    end else begin
      acc_b    = level_b ^ mb_level;
      mb_rise  = acc_b & level_b;
      mb_fall  = acc_b & ~level_b;
      mb_edge  = (mb_rise & rise_mask(mode_b)) | (mb_fall & fall_mask(mode_b));
      mb_level = level_b;
      mb_pend  = mb_edge | (mb_pend & ~clear_b);
      mb_any   = |mb_pend;
    end
  end

  logic [5*W:0] dut_a_vec, exp_a_vec, dut_b_vec, exp_b_vec;
  assign dut_a_vec = {lvl_a, rise_a, fall_a, edge_a, pend_a, any_a};
  assign exp_a_vec = {m_level, m_rise, m_fall, m_edge, m_pend, m_any};
  assign dut_b_vec = {lvl_b, rise_b, fall_b, edge_b, pend_b, any_b};
  assign exp_b_vec = {mb_level, mb_rise, mb_fall, mb_edge, mb_pend, mb_any};

  task automatic test_reset();
    rst_n = 1'b0; level_a = 4'hF; mode_a = 8'h55; clear_a = '0;
    level_b = '0; mode_b = 8'hFF; clear_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_a_vec !== '0) $display("[TB] FAIL reset_a: got %h expected 0", dut_a_vec);
    else n_pass++;
    n_checks++;
    if (dut_b_vec !== '0) $display("[TB] FAIL reset_b: got %h expected 0", dut_b_vec);
    else n_pass++;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_a_vec !== exp_a_vec) $display("[TB] FAIL reset_model k=%0d: got %h expected %h", k, dut_a_vec, exp_a_vec);
      else n_pass++;
      n_checks++;
      if (rise_a !== ((k == 5) ? 4'hF : 4'h0)) $display("[TB] FAIL reset_rise k=%0d: got %h expected %h", k, rise_a, (k == 5) ? 4'hF : 4'h0);
      else n_pass++;
    end
    n_checks++;
    if (lvl_a !== 4'hF) $display("[TB] FAIL reset_level: got %h expected f", lvl_a);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic seen;
    level_a = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_a_vec !== exp_a_vec) $display("[TB] FAIL glitch_settle k=%0d: got %h expected %h", k, dut_a_vec, exp_a_vec);
      else n_pass++;
    end
    clear_a = 4'hF;
    @(negedge clk);
    clear_a = '0;
    seen = 1'b0;
    level_a[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_a_vec !== exp_a_vec) $display("[TB] FAIL glitch3_model k=%0d: got %h expected %h", k, dut_a_vec, exp_a_vec);
      else n_pass++;
      seen = seen | rise_a[0] | edge_a[0] | pend_a[0] | lvl_a[0];
      if (k == 2) level_a[0] = 1'b0;
    end
    n_checks++;
    if (seen !== 1'b0) $display("[TB] FAIL glitch3_reject: got %b expected 0", seen);
    else n_pass++;
    level_a[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_a_vec !== exp_a_vec) $display("[TB] FAIL glitch4_model k=%0d: got %h expected %h", k, dut_a_vec, exp_a_vec);
      else n_pass++;
      if (k == 5) begin
        n_checks++;
        if (rise_a[0] !== 1'b1) $display("[TB] FAIL glitch4_rise: got %b expected 1", rise_a[0]);
        else n_pass++;
      end
      if (k == 3) level_a[0] = 1'b0;
    end
  endtask

  task automatic test_modes();
    mode_a = 8'b00_11_10_01;
    level_a = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_a_vec !== exp_a_vec) $display("[TB] FAIL modes_rise_model k=%0d: got %h expected %h", k, dut_a_vec, exp_a_vec);
      else n_pass++;
      if (k == 5) begin
        n_checks++;
        if ({edge_a, rise_a} !== {4'b0101, 4'hF}) $display("[TB] FAIL modes_rise: got %h expected 5f", {edge_a, rise_a});
        else n_pass++;
      end
    end
    level_a = 4'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_a_vec !== exp_a_vec) $display("[TB] FAIL modes_fall_model k=%0d: got %h expected %h", k, dut_a_vec, exp_a_vec);
      else n_pass++;
      if (k == 5) begin
        n_checks++;
        if ({edge_a, fall_a} !== {4'b0110, 4'hF}) $display("[TB] FAIL modes_fall: got %h expected 6f", {edge_a, fall_a});
        else n_pass++;
      end
    end
  endtask

  task automatic test_pending();
    clear_a = 4'hF;
    @(negedge clk);
    clear_a = '0;
    level_a = 4'b0100;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_a_vec !== exp_a_vec) $display("[TB] FAIL pend_set_model k=%0d: got %h expected %h", k, dut_a_vec, exp_a_vec);
      else n_pass++;
      if (k == 5) begin
        n_checks++;
        if ({pend_a, any_a} !== {4'b0100, 1'b1}) $display("[TB] FAIL pend_set: got %h expected 09", {pend_a, any_a});
        else n_pass++;
      end
    end
    clear_a = 4'b0100;
    @(negedge clk);
    n_checks++;
    if ({pend_a, any_a} !== 5'b0) $display("[TB] FAIL pend_clear: got %h expected 00", {pend_a, any_a});
    else n_pass++;
    level_a = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_a_vec !== exp_a_vec) $display("[TB] FAIL pend_race_model k=%0d: got %h expected %h", k, dut_a_vec, exp_a_vec);
      else n_pass++;
      if (k == 5) begin
        n_checks++;
        if ({edge_a[2], pend_a[2], any_a} !== 3'b111) $display("[TB] FAIL pend_set_wins: got %b expected 111", {edge_a[2], pend_a[2], any_a});
        else n_pass++;
      end
    end
    clear_a = '0;
  endtask

  task automatic test_mid_reset();
    level_a = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_a_vec !== exp_a_vec) $display("[TB] FAIL midrst_pre k=%0d: got %h expected %h", k, dut_a_vec, exp_a_vec);
      else n_pass++;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dut_a_vec !== '0) $display("[TB] FAIL midrst_zero: got %h expected 0", dut_a_vec);
    else n_pass++;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_a_vec !== exp_a_vec) $display("[TB] FAIL midrst_model k=%0d: got %h expected %h", k, dut_a_vec, exp_a_vec);
      else n_pass++;
      n_checks++;
      if (rise_a !== ((k == 5) ? 4'hF : 4'h0)) $display("[TB] FAIL midrst_rise k=%0d: got %h expected %h", k, rise_a, (k == 5) ? 4'hF : 4'h0);
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    level_b = 4'b0010;
    @(negedge clk);
    n_checks++;
    if ({rise_b, lvl_b} !== {4'b0010, 4'b0010}) $display("[TB] FAIL bypass_rise: got %h expected 22", {rise_b, lvl_b});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rise_b !== 4'b0000) $display("[TB] FAIL bypass_one_cycle: got %h expected 0", rise_b);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      level_b[1] = ~level_b[1];
      @(negedge clk);
      n_checks++;
      if ({rise_b[1], fall_b[1]} !== {level_b[1], ~level_b[1]}) $display("[TB] FAIL bypass_toggle k=%0d: got %b expected %b", k, {rise_b[1], fall_b[1]}, {level_b[1], ~level_b[1]});
      else n_pass++;
      n_checks++;
      if (dut_b_vec !== exp_b_vec) $display("[TB] FAIL bypass_model k=%0d: got %h expected %h", k, dut_b_vec, exp_b_vec);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut_a_vec !== exp_a_vec) $display("[TB] FAIL rand_a k=%0d: got %h expected %h", k, dut_a_vec, exp_a_vec);
      else n_pass++;
      n_checks++;
      if (dut_b_vec !== exp_b_vec) $display("[TB] FAIL rand_b k=%0d: got %h expected %h", k, dut_b_vec, exp_b_vec);
      else n_pass++;
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 3) == 0) level_a[c] = ~level_a[c];
      if ($urandom_range(0, 15) == 0) mode_a = 8'($urandom);
      clear_a = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      level_b = 4'($urandom);
      mode_b  = 8'($urandom);
      clear_b = 4'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_modes();
    test_pending();
    test_mid_reset();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
